// File: rtl/debug_word_sender_pkg.sv
// debug_word_sender_pkg
//   Constants and types shared by the debug unit, the UART and the
//   debug word sender.
//   - DBG_BITS_SIZE / DBG_SIZE_TRAMA / DBG_ADDR_SIZE: default widths.
//   - DBG_NBYTES: UART frames per debug word for the default widths.
//   - dws_state_e: 3-bit state encoding of the word sender FSM.
//   - idx_width(): counter width able to index n items (minimum 1 bit).
package debug_word_sender_pkg;

  localparam int DBG_BITS_SIZE  = 32;
  localparam int DBG_SIZE_TRAMA = 8;
  localparam int DBG_ADDR_SIZE  = 5;
  localparam int DBG_NBYTES     = DBG_BITS_SIZE / DBG_SIZE_TRAMA;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
    ST_WAIT = 3'd4,
    ST_DONE = 3'd5
  } dws_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debug_word_sender.sv
// debug_word_sender
//   Walks a word-addressed debug source from address 0 to count-1 and
//   sends every word to the UART as SIZE_TRAMA-bit frames, LSB frame first.
//   Ports:
//     i_clk, i_reset      clock, asynchronous active-high reset
//     i_start             one-cycle transfer request (ignored while busy)
//     i_word_count        words to send, 0..2^ADDR_SIZE, sampled on start
//     i_word_data         source word at o_word_addr (combinational source)
//     i_tx_done           UART frame-finished pulse
//     o_word_addr         address presented to the source
//     o_tx_start          one-cycle UART transmit request
//     o_tx_data           frame to transmit, stable until i_tx_done
//     o_busy              transfer in progress
//     o_done              one-cycle completion pulse
module debug_word_sender
  import debug_word_sender_pkg::*;
#(
  parameter int BITS_SIZE  = DBG_BITS_SIZE,
  parameter int SIZE_TRAMA = DBG_SIZE_TRAMA,
  parameter int ADDR_SIZE  = DBG_ADDR_SIZE
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_SIZE:0]    i_word_count,
  input  logic [BITS_SIZE-1:0]  i_word_data,
  input  logic                  i_tx_done,
  output logic [ADDR_SIZE-1:0]  o_word_addr,
  output logic                  o_tx_start,
  output logic [SIZE_TRAMA-1:0] o_tx_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int NBYTES     = BITS_SIZE / SIZE_TRAMA;
  localparam int BYTE_IDX_W = idx_width(NBYTES);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(NBYTES - 1);

  dws_state_e state_q, state_d;

  logic [ADDR_SIZE:0]    count_q,    count_d;
  logic [ADDR_SIZE-1:0]  addr_q,     addr_d;
  logic [BITS_SIZE-1:0]  word_q,     word_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;

  logic last_byte;
  logic more_words;

  assign last_byte = (byte_idx_q == LAST_BYTE);
  // The address doubles as the word index. Comparing in ADDR_SIZE+1 bits
  // lets count = 2^ADDR_SIZE stop at address 2^ADDR_SIZE-1 without wrapping;
  // count-1 cannot underflow here because count=0 never reaches WAIT.
  assign more_words = ({1'b0, addr_q} < (count_q - (ADDR_SIZE + 1)'(1)));

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = (i_word_count == '0) ? ST_DONE : ST_ADDR;
        end
      end
      ST_ADDR: state_d = ST_LOAD;
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) begin
          if (!last_byte) begin
            state_d = ST_SEND;
          end else if (more_words) begin
            state_d = ST_ADDR;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: latched count, address/word index, captured word, frame index
  always_comb begin
    count_d    = count_q;
    addr_d     = addr_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          count_d = i_word_count;
          addr_d  = '0;
        end
      end
      ST_LOAD: begin
        // Captured once; later source changes do not disturb this word.
        word_d     = i_word_data;
        byte_idx_d = '0;
      end
      ST_WAIT: begin
        if (i_tx_done) begin
          if (!last_byte) begin
            byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
          end else if (more_words) begin
            addr_d = addr_q + ADDR_SIZE'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q    <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
    end else begin
      count_q    <= count_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  // Outputs. The frame mux reads only registers, so o_tx_data stays put
  // from SEND until the frame index advances on i_tx_done.
  always_comb begin
    o_word_addr = addr_q;
    o_tx_start  = (state_q == ST_SEND);
    o_busy      = (state_q != ST_IDLE);
    o_done      = (state_q == ST_DONE);
    o_tx_data   = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (byte_idx_q == BYTE_IDX_W'(i)) begin
        o_tx_data = word_q[i*SIZE_TRAMA +: SIZE_TRAMA];
      end
    end
  end

endmodule

// File: tb/tb_debug_word_sender.sv
module tb_debug_word_sender;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic [5:0]  i_word_count;
  logic [31:0] i_word_data;
  logic        i_tx_done;
  logic [4:0]  o_word_addr;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic        o_done;

  debug_word_sender #(
    .BITS_SIZE (32),
    .SIZE_TRAMA(8),
    .ADDR_SIZE (5)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_word_count(i_word_count),
    .i_word_data (i_word_data),
    .i_tx_done   (i_tx_done),
    .o_word_addr (o_word_addr),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Combinational word source
  logic [31:0] src_mem [32];
  assign i_word_data = src_mem[o_word_addr];

  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];
  int   tx_count   = 0;
  int   done_count = 0;
  int   max_addr   = 0;
  bit   glitch_en  = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endfunction

  function automatic void push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[b*8 +: 8]);
  endfunction

  // Monitor: pops an expected frame on every o_tx_start
  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        if (o_tx_start) begin
          tx_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got frame %0h expected no frame (t=%0t)", o_tx_data, $time);
          end else begin
            chk("tx_byte", {24'h0, o_tx_data}, {24'h0, exp_q.pop_front()});
          end
        end
        if (o_done) done_count++;
        if (int'(o_word_addr) > max_addr) max_addr = int'(o_word_addr);
      end
    end
  end

  // UART model: tx_done 10 cycles after each tx_start; optional bogus
  // tx_done during the SEND cycle itself.
  initial begin
    int cnt;
    logic [7:0] held;
    cnt = 0;
    held = '0;
    i_tx_done = 1'b0;
    forever begin
      @(negedge i_clk);
      i_tx_done = 1'b0;
      if (i_reset) begin
        cnt = 0;
      end else if (o_tx_start) begin
        held = o_tx_data;
        cnt = 9;
        if (glitch_en) i_tx_done = 1'b1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          chk("tx_data_hold", {24'h0, o_tx_data}, {24'h0, held});
          i_tx_done = 1'b1;
        end
      end
    end
  end

  task automatic pulse_start(input logic [5:0] cnt);
    @(negedge i_clk);
    i_start = 1'b1;
    i_word_count = cnt;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Returns at the negedge where o_done is seen; a timeout counts as failure.
  task automatic wait_done(input string name, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cycles && !seen; k++) begin
      @(negedge i_clk);
      if (o_done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: got no o_done expected o_done within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    int base_tx, base_done, k;
    bit seen;

    i_reset = 1'b1;
    i_start = 1'b0;
    i_word_count = '0;
    for (int a = 0; a < 32; a++) src_mem[a] = '0;

    #2;
    chk("reset_outputs", {16'h0, o_word_addr, o_tx_start, o_tx_data, o_busy, o_done}, 32'h0);
    idle_cycles(3);
    i_reset = 1'b0;
    idle_cycles(2);

    // Test 1: single word, LSB frame first, 3-cycle start latency
    src_mem[0] = 32'h11223344;
    push_word(32'h11223344);
    base_tx = tx_count; base_done = done_count;
    chk("t1_busy_before", {31'h0, o_busy}, 32'h0);
    pulse_start(6'd1);
    k = 1;
    while (!o_tx_start && k < 20) begin
      @(negedge i_clk);
      k++;
    end
    chk("t1_first_tx_latency", k, 3);
    wait_done("t1_done", 200);
    chk("t1_tx_count", tx_count - base_tx, 4);
    @(negedge i_clk);
    chk("t1_busy_after", {31'h0, o_busy}, 32'h0);
    chk("t1_done_count", done_count - base_done, 1);
    chk("t1_queue_empty", exp_q.size(), 0);

    // Test 2: full 32-word sweep
    for (int a = 0; a < 32; a++) begin
      src_mem[a] = a * 32'h01010101;
      push_word(a * 32'h01010101);
    end
    base_tx = tx_count; base_done = done_count; max_addr = 0;
    pulse_start(6'd32);
    wait_done("t2_done", 5000);
    chk("t2_last_addr", {27'h0, o_word_addr}, 32'd31);
    idle_cycles(5);
    chk("t2_max_addr", max_addr, 31);
    chk("t2_tx_count", tx_count - base_tx, 128);
    chk("t2_done_count", done_count - base_done, 1);
    chk("t2_queue_empty", exp_q.size(), 0);

    // Test 3: zero words; IDLE goes straight to DONE
    base_tx = tx_count; base_done = done_count;
    pulse_start(6'd0);
    chk("t3_done_pulse", {30'h0, o_busy, o_done}, 32'h3);
    @(negedge i_clk);
    chk("t3_after_done", {30'h0, o_busy, o_done}, 32'h0);
    idle_cycles(5);
    chk("t3_tx_count", tx_count - base_tx, 0);
    chk("t3_done_count", done_count - base_done, 1);

    // Test 4: spurious starts while busy, tx_done glitch on SEND cycles
    src_mem[0] = 32'h55667788;
    src_mem[1] = 32'h99AABBCC;
    push_word(32'h55667788);
    push_word(32'h99AABBCC);
    base_tx = tx_count; base_done = done_count;
    glitch_en = 1'b1;
    pulse_start(6'd2);
    i_word_count = 6'd7;
    seen = 1'b0;
    for (int j = 0; j < 500 && !seen; j++) begin
      @(negedge i_clk);
      if (o_done) seen = 1'b1;
      i_start = (!seen && (j % 6 == 3));
    end
    i_start = 1'b0;
    glitch_en = 1'b0;
    chk("t4_done_seen", {31'h0, seen}, 32'h1);
    idle_cycles(30);
    chk("t4_tx_count", tx_count - base_tx, 8);
    chk("t4_done_count", done_count - base_done, 1);
    chk("t4_busy_after", {31'h0, o_busy}, 32'h0);
    chk("t4_queue_empty", exp_q.size(), 0);

    // Test 5: asynchronous reset during WAIT of frame 2 of word 0
    src_mem[0] = 32'h01020304;
    src_mem[1] = 32'h05060708;
    push_word(32'h01020304);
    push_word(32'h05060708);
    base_tx = tx_count;
    pulse_start(6'd2);
    for (int j = 0; j < 200 && (tx_count - base_tx) < 2; j++) @(negedge i_clk);
    chk("t5_reached_frame2", tx_count - base_tx, 2);
    idle_cycles(2);
    #2 i_reset = 1'b1;
    #1;
    chk("t5_async_reset_outputs", {16'h0, o_word_addr, o_tx_start, o_tx_data, o_busy, o_done}, 32'h0);
    exp_q.delete();
    idle_cycles(2);
    i_reset = 1'b0;
    base_tx = tx_count; base_done = done_count;
    idle_cycles(30);
    chk("t5_no_tx_after_abort", tx_count - base_tx, 0);
    chk("t5_no_done_after_abort", done_count - base_done, 0);
    src_mem[0] = 32'hA1B2C3D4;
    push_word(32'hA1B2C3D4);
    pulse_start(6'd1);
    chk("t5_restart_addr", {27'h0, o_word_addr}, 32'h0);
    wait_done("t5_done", 200);
    idle_cycles(3);
    chk("t5_tx_count", tx_count - base_tx, 4);
    chk("t5_queue_empty", exp_q.size(), 0);

    // Test 6: source changes after LOAD do not affect the current word
    src_mem[0] = 32'hCAFEBABE;
    push_word(32'hCAFEBABE);
    base_tx = tx_count;
    pulse_start(6'd1);
    for (int j = 0; j < 50 && tx_count == base_tx; j++) @(negedge i_clk);
    src_mem[0] = 32'h0BADF00D;
    wait_done("t6_done", 200);
    idle_cycles(3);
    chk("t6_tx_count", tx_count - base_tx, 4);
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
